imem_loader: RTL and testbench

Instruction-side responder for the pipelined RISC-V core. It answers the core's fetch port (`pc` in, `instr` out) from an internal word RAM, and fills that RAM from an external byte-stream loader. While a program is loading, it holds the core in reset through `cpu_rst`. When loading completes it releases the core, which then fetches from address 0.

---
 rtl/imem_loader.sv | 108 ++++++++++
 tb/tb_imem_loader.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Instruction memory for the pipelined core: answers fetches combinationally from a
// word RAM and refills that RAM from a byte-stream loader while holding the core in reset.
module imem_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int ADDR_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] instr,
  output logic                  cpu_rst,
  input  logic                  ld_start,
  input  logic                  ld_valid,
  input  logic [7:0]            ld_data,
  output logic                  ld_ready,
  input  logic                  ld_done,
  output logic                  load_err,
  output logic                  fetch_err,
  output logic [ADDR_W:0]       word_count
);

  localparam logic [DATA_WIDTH-1:0] NOP  = 32'h0000_0013;
  localparam logic [ADDR_W:0]       FULL = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t                state, state_nx;
  logic [ADDR_W:0]       wptr, wptr_nx;
  logic [1:0]            lane, lane_nx;
  logic [23:0]           asm_q;
  logic [DATA_WIDTH-1:0] ram [DEPTH];
  logic                  accept, wr_en, full;
  logic                  cpu_rst_nx, ld_ready_nx;
  logic [ADDR_W-1:0]     idx;
  logic                  hit;

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (ld_start) state_nx = LOAD;
      LOAD:    if (ld_done)  state_nx = RUN;
      RUN:     if (ld_start) state_nx = LOAD;
      default: state_nx = IDLE;
    endcase
  end

  // cpu_rst and ld_ready are registered from the next state so they line up with it
  always_comb begin
    cpu_rst_nx  = (state_nx != RUN);
    ld_ready_nx = (state_nx == LOAD) && (wptr_nx < FULL);
  end

  always_comb begin
    full   = (wptr == FULL);
    accept = (state == LOAD) && ld_valid && ld_ready;
    wr_en  = accept && (lane == 2'd3);
    lane_nx = lane;
    wptr_nx = wptr;
    if (state != LOAD && state_nx == LOAD) begin
      lane_nx = '0;
      wptr_nx = '0;
    end else if (accept) begin
      lane_nx = lane + 2'd1;
      if (wr_en) wptr_nx = wptr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_rst    <= 1'b1;
      ld_ready   <= 1'b0;
      load_err   <= 1'b0;
      fetch_err  <= 1'b0;
      word_count <= '0;
      wptr       <= '0;
      lane       <= '0;
      asm_q      <= '0;
    end else begin
      cpu_rst  <= cpu_rst_nx;
      ld_ready <= ld_ready_nx;
      wptr     <= wptr_nx;
      lane     <= lane_nx;
      if (accept && lane != 2'd3) asm_q[{lane, 3'b000} +: 8] <= ld_data;
      // completion checks see the byte accepted in the same cycle as ld_done
      if (state == IDLE && ld_start)
        load_err <= 1'b0;
      else if (state == LOAD && ((ld_valid && full) || (ld_done && lane_nx != 2'd0)))
        load_err <= 1'b1;
      if (state == LOAD && ld_done) word_count <= wptr_nx;
      if (state == RUN && pc[1:0] != 2'b00) fetch_err <= 1'b1;
    end
  end

  always_ff @(posedge clk)
    if (wr_en) ram[wptr[ADDR_W-1:0]] <= {ld_data, asm_q};

  always_comb begin
    idx   = pc[ADDR_W+1:2];
    hit   = (pc[1:0] == 2'b00) && (pc[DATA_WIDTH-1:ADDR_W+2] == '0) && ({1'b0, idx} < word_count);
    instr = hit ? ram[idx] : NOP;
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader against a byte-count based reference model.
module tb_imem_loader;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic        clk = 0, rst = 1;
  logic [31:0] pc = 0;
  logic [31:0] instr;
  logic        cpu_rst, ld_start = 0, ld_valid = 0, ld_ready, ld_done = 0;
  logic        load_err, fetch_err;
  logic [7:0]  ld_data = 0;
  logic [AW:0] word_count;

  imem_loader #(.DATA_WIDTH(32), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .pc(pc), .instr(instr), .cpu_rst(cpu_rst),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .ld_done(ld_done), .load_err(load_err), .fetch_err(fetch_err), .word_count(word_count)
  );

  always #5 clk = ~clk;

  int vec = 0, err = 0;

  // reference model: mode 0 idle, 1 load, 2 run; n = bytes accepted this load
  int          m_mode = 0, m_n = 0, m_wc = 0;
  bit          m_lerr = 0, m_ferr = 0;
  logic [7:0]  m_bytes [4*DEPTH];
  logic [31:0] m_mem [DEPTH];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vec++;
    if (obs !== exp) begin
      err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_instr(logic [31:0] a);
    if (a[1:0] == 0 && (a >> (AW + 2)) == 0 && int'(a >> 2) < m_wc) return m_mem[a >> 2];
    return 32'h0000_0013;
  endfunction

  task automatic model_step();
    if (m_mode == 2 && pc[1:0] != 0) m_ferr = 1;
    case (m_mode)
      0: if (ld_start) begin m_mode = 1; m_n = 0; m_lerr = 0; end
      1: begin
        if (ld_valid) begin
          if (m_n < 4*DEPTH) begin
            m_bytes[m_n] = ld_data;
            if (m_n % 4 == 3)
              m_mem[m_n/4] = {m_bytes[m_n], m_bytes[m_n-1], m_bytes[m_n-2], m_bytes[m_n-3]};
            m_n++;
          end else m_lerr = 1;
        end
        if (ld_done) begin
          m_wc = m_n / 4;
          if (m_n % 4 != 0) m_lerr = 1;
          m_mode = 2;
        end
      end
      default: if (ld_start) begin m_mode = 1; m_n = 0; end
    endcase
  endtask

  task automatic check_all();
    chk("cpu_rst",    {31'd0, cpu_rst},   {31'd0, m_mode != 2});
    chk("ld_ready",   {31'd0, ld_ready},  {31'd0, m_mode == 1 && m_n/4 < DEPTH});
    chk("load_err",   {31'd0, load_err},  {31'd0, m_lerr});
    chk("fetch_err",  {31'd0, fetch_err}, {31'd0, m_ferr});
    chk("word_count", {29'd0, word_count}, 32'(m_wc));
    chk("instr",      instr,              exp_instr(pc));
  endtask

  task automatic drv(bit s, bit v, logic [7:0] d, bit dn, logic [31:0] p);
    ld_start = s; ld_valid = v; ld_data = d; ld_done = dn; pc = p;
    @(posedge clk);
    model_step();
    #1;
    check_all();
    ld_start = 0; ld_valid = 0; ld_done = 0;
  endtask

  task automatic set_pc(logic [31:0] p, logic [31:0] want, string tag);
    pc = p;
    #1;
    chk(tag, instr, want);
  endtask

  task automatic do_rst();
    #2 rst = 1;
    m_mode = 0; m_n = 0; m_wc = 0; m_lerr = 0; m_ferr = 0;
    #1 check_all();
    @(negedge clk) rst = 0;
  endtask

  function automatic logic [31:0] rand_pc();
    int r = $urandom % 16;
    if (r == 0) return 32'($urandom_range(0, 31));
    if (r == 1) return 32'h100 | ((32'($urandom) % 8) << 2);
    return (32'($urandom) % 8) << 2;
  endfunction

  logic [7:0] prog [8];
  initial begin
    prog = '{8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01, 8'h20, 8'h00};
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 0;
    #1 check_all();
    drv(0, 0, 0, 0, 0);

    // basic load
    drv(1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) drv(0, 1, prog[i], 0, 0);
    drv(0, 0, 0, 1, 0);
    chk("basic_wc", {29'd0, word_count}, 32'd2);
    chk("basic_cpu_rst", {31'd0, cpu_rst}, 32'd0);
    chk("basic_err", {31'd0, load_err}, 32'd0);
    set_pc(0, 32'h0010_0093, "basic_pc0");
    set_pc(4, 32'h0020_0113, "basic_pc4");
    set_pc(8, 32'h0000_0013, "basic_pc8");

    // reload from RUN, partial word
    drv(1, 0, 0, 0, 0);
    chk("reload_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    chk("reload_wc_hold", {29'd0, word_count}, 32'd2);
    for (int i = 0; i < 6; i++) drv(0, 1, prog[i], 0, 0);
    drv(0, 0, 0, 1, 0);
    chk("partial_wc", {29'd0, word_count}, 32'd1);
    chk("partial_err", {31'd0, load_err}, 32'd1);
    set_pc(4, 32'h0000_0013, "partial_pc4");

    // overflow with ld_valid held
    drv(1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      drv(0, 1, 8'(i + 1), 0, 0);
      if (i == 15) chk("ovf_ready_low", {31'd0, ld_ready}, 32'd0);
    end
    drv(0, 0, 0, 1, 0);
    chk("ovf_err", {31'd0, load_err}, 32'd1);
    chk("ovf_wc", {29'd0, word_count}, 32'd4);
    set_pc(12, 32'h100f0e0d, "ovf_pc12");

    // async reset mid-load
    drv(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) drv(0, 1, 8'hA0 + 8'(i), 0, 0);
    do_rst();
    chk("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    chk("rst_wc", {29'd0, word_count}, 32'd0);

    // last byte together with done
    drv(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) drv(0, 1, prog[i], 0, 0);
    drv(0, 1, prog[3], 1, 0);
    chk("simul_wc", {29'd0, word_count}, 32'd1);
    chk("simul_err", {31'd0, load_err}, 32'd0);
    set_pc(0, 32'h0010_0093, "simul_pc0");

    // misaligned fetch while running
    drv(0, 0, 0, 0, 2);
    chk("misal_instr", instr, 32'h0000_0013);
    chk("misal_ferr", {31'd0, fetch_err}, 32'd1);
    drv(0, 0, 0, 0, 0);
    chk("ferr_sticky", {31'd0, fetch_err}, 32'd1);

    // zero-length load
    drv(1, 0, 0, 0, 0);
    drv(0, 0, 0, 1, 0);
    chk("zero_wc", {29'd0, word_count}, 32'd0);
    chk("zero_nop", instr, 32'h0000_0013);

    // randomized loads and run phases
    for (int it = 0; it < 40; it++) begin
      int  k = $urandom_range(0, 20);
      int  sent = 0;
      bit  done = 0, aborted = 0;
      drv(1, 0, 0, 0, rand_pc());
      while (sent < k && !aborted) begin
        bit v  = ($urandom % 4) != 0;
        bit s  = ($urandom % 8) == 0;
        bit dn = v && sent == k - 1 && ($urandom % 2);
        drv(s, v, 8'($urandom), dn, rand_pc());
        if (v) sent++;
        if (dn) done = 1;
        if ($urandom % 60 == 0) begin do_rst(); aborted = 1; end
      end
      if (!aborted && !done) drv(0, 0, 0, 1, rand_pc());
      if (!aborted)
        for (int c = 0, nc = $urandom_range(3, 10); c < nc; c++)
          drv(0, ($urandom % 4) == 0, 8'($urandom), ($urandom % 4) == 0, rand_pc());
      if ($urandom % 5 == 0) do_rst();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
